// File: rtl/vga_pkg.sv
// Default 800x600@60 timing constants, shared pixel struct and colour-bar helper.
// Test-pattern colour bars are enabled by the VGA_TEST_PATTERN_EN macro.
package vga_pkg;

    localparam int COUNT_W   = 11;

    localparam int H_VISIBLE = 800;
    localparam int H_FP      = 40;
    localparam int H_SYNC    = 128;
    localparam int H_BP      = 88;
    localparam int V_VISIBLE = 600;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 4;
    localparam int V_BP      = 23;

    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_VISIBLE + H_FP;
    localparam int HS_END    = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_START  = V_VISIBLE + V_FP;
    localparam int VS_END    = V_VISIBLE + V_FP + V_SYNC;

    typedef struct packed {
        logic [COUNT_W-1:0] hcount;
        logic [COUNT_W-1:0] vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
        logic [11:0]        rgb;
    } vga_pix_t;

    // Bar index bits map straight onto the R, G and B nibbles.
    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle passed between every stage of the VGA pipeline.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis counter; count is the next (about to be registered) value.
module vga_axis_counter #(
    parameter int TOTAL = 1056,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap_in,
    output logic [WIDTH-1:0] count,
    output logic             wrap_out
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             step;

    always_comb begin
        step     = en & wrap_in;
        wrap_out = step && (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Parking on LAST makes the first enabled step after reset land on 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the VGA pipeline: raster counters, syncs, blanking and background rgb.
// Define VGA_TEST_PATTERN_EN to paint 8 vertical colour bars in the visible area.
module vga_timing_gen #(
    parameter int   H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int   H_FP      = vga_pkg::H_FP,
    parameter int   H_SYNC    = vga_pkg::H_SYNC,
    parameter int   H_BP      = vga_pkg::H_BP,
    parameter int   V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int   V_FP      = vga_pkg::V_FP,
    parameter int   V_SYNC    = vga_pkg::V_SYNC,
    parameter int   V_BP      = vga_pkg::V_BP,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_if.out   out,
    output logic frame_tick,
    output logic line_tick
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [COUNT_W-1:0] H_VIS_C  = COUNT_W'(H_VISIBLE);
    localparam logic [COUNT_W-1:0] V_VIS_C  = COUNT_W'(V_VISIBLE);
    localparam logic [COUNT_W-1:0] HS_BEG_C = COUNT_W'(H_VISIBLE + H_FP);
    localparam logic [COUNT_W-1:0] HS_END_C = COUNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [COUNT_W-1:0] VS_BEG_C = COUNT_W'(V_VISIBLE + V_FP);
    localparam logic [COUNT_W-1:0] VS_END_C = COUNT_W'(V_VISIBLE + V_FP + V_SYNC);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    logic [COUNT_W-1:0] h_d;
    logic [COUNT_W-1:0] v_d;
    logic               h_wrap;
    logic               v_wrap;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .WIDTH (COUNT_W)
    ) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wrap_in  (1'b1),
        .count    (h_d),
        .wrap_out (h_wrap)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .WIDTH (COUNT_W)
    ) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wrap_in  (h_wrap),
        .count    (v_d),
        .wrap_out (v_wrap)
    );

    vga_pix_t pix_q;
    vga_pix_t pix_d;
    logic     frame_tick_q;
    logic     line_tick_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [COUNT_W-1:0] BAR_W_C = COUNT_W'(H_VISIBLE / 8);
    logic [COUNT_W-1:0] bar_idx;
    logic [2:0]         bar_sel;
`endif

    // Flags derive from the next counter values so they align with the registered counts.
    always_comb begin
        pix_d.hcount = h_d;
        pix_d.vcount = v_d;
        pix_d.hblnk  = (h_d >= H_VIS_C);
        pix_d.vblnk  = (v_d >= V_VIS_C);
        pix_d.hsync  = ((h_d >= HS_BEG_C) && (h_d < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
        pix_d.vsync  = ((v_d >= VS_BEG_C) && (v_d < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
`ifdef VGA_TEST_PATTERN_EN
        bar_idx   = h_d / BAR_W_C;
        bar_sel   = (|bar_idx[COUNT_W-1:3]) ? 3'd7 : bar_idx[2:0];
        pix_d.rgb = (pix_d.hblnk || pix_d.vblnk) ? '0 : bar_rgb(bar_sel);
`else
        pix_d.rgb = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '{hcount: '0, vcount: '0, hsync: ~SYNC_POL, vsync: ~SYNC_POL,
                       hblnk: 1'b0, vblnk: 1'b0, rgb: '0};
            frame_tick_q <= 1'b0;
            line_tick_q  <= 1'b0;
        end else if (en) begin
            pix_q        <= pix_d;
            frame_tick_q <= v_wrap;
            line_tick_q  <= h_wrap;
        end else begin
            frame_tick_q <= 1'b0;
            line_tick_q  <= 1'b0;
        end
    end

    assign out.hcount = pix_q.hcount;
    assign out.vcount = pix_q.vcount;
    assign out.hsync  = pix_q.hsync;
    assign out.vsync  = pix_q.vsync;
    assign out.hblnk  = pix_q.hblnk;
    assign out.vblnk  = pix_q.vblnk;
    assign out.rgb    = pix_q.rgb;
    assign frame_tick = frame_tick_q;
    assign line_tick  = line_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default horizontal timing, shortened frame (12 lines).
module tb_vga_timing_gen;

    localparam int HT = 1056;
    localparam int VT = 12;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        ft;
        logic        lt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic frame_tick;
    logic line_tick;

    vga_if vif ();

    vga_timing_gen #(
        .V_VISIBLE (6),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (3),
        .SYNC_POL  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out        (vif),
        .frame_tick (frame_tick),
        .line_tick  (line_tick)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    bit   steady_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: last presented position and "first step after reset" flag.
    int   mh = 0;
    int   mv = 0;
    bit   fresh = 1'b1;
    exp_t m = '0;

    function automatic logic [11:0] model_rgb(input int h, input int v);
        logic [11:0] bars [8];
        bars = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
`ifdef VGA_TEST_PATTERN_EN
        if (h >= 800 || v >= 6) return 12'h000;
        return bars[h / 100];
`else
        return 12'h000;
`endif
    endfunction

    task automatic cyc(input logic r, input logic e);
        rst = r;
        en  = e;
        if (r) begin
            mh = 0; mv = 0; fresh = 1'b1;
            m  = '{h: 11'd0, v: 11'd0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0,
                   rgb: 12'h000, ft: 1'b0, lt: 1'b0};
        end else if (e) begin
            if (fresh) fresh = 1'b0;
            else begin
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == VT) mv = 0;
                end
            end
            m.h   = 11'(mh);
            m.v   = 11'(mv);
            m.hb  = (mh >= 800);
            m.vb  = (mv >= 6);
            m.hs  = (mh >= 840 && mh < 968);
            m.vs  = (mv >= 7 && mv < 9);
            m.rgb = model_rgb(mh, mv);
            m.lt  = (mh == 0);
            m.ft  = (mh == 0 && mv == 0);
        end else begin
            m.ft = 1'b0;
            m.lt = 1'b0;
        end
        sb_q.push_back(m);
        steady_q.push_back(!r && e);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: one pixel per clock; pops the expected pixel and runs timing checks.
    int  hs_run = 0, vs_run = 0, per_cnt = 0;
    bit  per_valid = 1'b0;
    int  prev_h = 0, prev_v = 0;

    always begin
        exp_t e, g;
        bit   st;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            st = steady_q.pop_front();
            g  = '{h: vif.hcount, v: vif.vcount, hs: vif.hsync, vs: vif.vsync,
                   hb: vif.hblnk, vb: vif.vblnk, rgb: vif.rgb, ft: frame_tick, lt: line_tick};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL pixel: got h=%0d v=%0d hs%b vs%b hb%b vb%b rgb=%h ft%b lt%b, required h=%0d v=%0d hs%b vs%b hb%b vb%b rgb=%h ft%b lt%b",
                         g.h, g.v, g.hs, g.vs, g.hb, g.vb, g.rgb, g.ft, g.lt,
                         e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb, e.ft, e.lt);
            end

            if (g.hs === 1'b1) begin
                if (hs_run == 0) check("hsync_start_h", int'(g.h), 840);
                hs_run++;
            end else if (hs_run > 0) begin
                check("hsync_width", hs_run, 128);
                check("hsync_end_h", int'(g.h), 968);
                hs_run = 0;
            end

            if (g.vs === 1'b1) begin
                if (vs_run == 0) check("vsync_start_hv", int'(g.h) * 10000 + int'(g.v), 7);
                vs_run++;
            end else if (vs_run > 0) begin
                check("vsync_width", vs_run, 2 * HT);
                vs_run = 0;
            end

            if (!st) per_valid = 1'b0;
            per_cnt++;
            if (g.ft === 1'b1) begin
                if (per_valid) check("frame_period", per_cnt, HT * VT);
                per_cnt   = 0;
                per_valid = st;
            end

            if (g.lt === 1'b1 && g.h == 0 && g.v == 1)
                check("line_wrap_prev", prev_h * 10000 + prev_v, 1055 * 10000);
            if (st && g.v == 0 && g.h == 799) check("hblnk_799", int'(g.hb), 0);
            if (st && g.v == 0 && g.h == 800) check("hblnk_800", int'(g.hb), 1);
            if (st && g.h == 0 && g.v == 6)   check("vblnk_600", int'(g.vb), 1);
`ifdef VGA_TEST_PATTERN_EN
            if (st && g.v == 2) begin
                if (g.h == 0)   check("bar_h0",   int'(g.rgb), 'h000);
                if (g.h == 100) check("bar_h100", int'(g.rgb), 'h00F);
                if (g.h == 799) check("bar_h799", int'(g.rgb), 'hFFF);
                if (g.h == 800) check("bar_h800", int'(g.rgb), 'h000);
            end
`endif
            prev_h = int'(g.h);
            prev_v = int'(g.v);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < HT * VT + 1100; i++) cyc(1'b0, 1'b1);
        while (mh != 100) cyc(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        while (!(mh == 500 && mv == 3)) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1);
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the vga_if pixel stream; generates hcount/vcount, hsync/vsync, hblnk/vblnk and a background rgb.
- Every downstream stage (background, sprite and rectangle drawers, mouse overlay) consumes this stream unchanged in format.
- Sits at the head of the top_vga pipeline; clocked by the 40 MHz pixel clock (800x600@60 default).

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_VISIBLE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width
- V_BP, 23, vertical back porch
- SYNC_POL, 1'b1, active level of hsync/vsync (1 = positive)

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset
- en  in  1  pixel advance enable; counters hold when low
- out  vga_if.out  -  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- frame_tick  out  1  one-cycle pulse when hcount=0 and vcount=0 is presented
- line_tick  out  1  one-cycle pulse when hcount=0 is presented

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- During reset: hcount=0, vcount=0, hsync=vsync=~SYNC_POL, hblnk=vblnk=0, rgb=0, frame_tick=0, line_tick=0.
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1056). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (628).
- Counters:
  - Internal h_cnt and v_cnt, 11-bit.
  - On en=1, h_cnt increments. When h_cnt=H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - When v_cnt=V_TOTAL-1 and h_cnt=H_TOTAL-1, both wrap to 0.
  - On en=0, everything holds, including ticks (ticks forced 0).
- All outputs are registered and computed from the next counter values, so the flags are zero-cycle aligned with the hcount/vcount they accompany:
  - hblnk = (hcount >= H_VISIBLE)
  - hsync = SYNC_POL when H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (840..967)
  - vblnk = (vcount >= V_VISIBLE)
  - vsync = SYNC_POL when V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (601..604)
  - vsync changes only together with a line change (hcount=0).
- First cycle after rst deasserts with en=1: output hcount=0, vcount=0 (frame_tick=1, line_tick=1). The next cycle outputs hcount=1.
- rgb: 12'h000 at all times (background stage paints).
- Reset mid-frame: counters return to 0,0 the cycle after rst is sampled. There is no partial-frame recovery.
- Width rule: the H_TOTAL and V_TOTAL parameters must be <= 2048. Elaboration check.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined: rgb in the visible area carries 8 vertical colour bars, each H_VISIBLE/8 wide. Bar index i = hcount/(H_VISIBLE/8), order 000, 00F, 0F0, 0FF, F00, F0F, FF0, FFF. rgb is 000 while blanked.
- Undefined: rgb is constant 000 and no bar logic is synthesized.

Decomposition:
- vga_pkg holds:
  - the default timing constants (H_VISIBLE...V_BP)
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - the COUNT_W=11 width constant
- One sub-module, vga_axis_counter:
  - parameterised total and width; en and wrap_in inputs, count and wrap_out outputs
  - instantiated twice, with the horizontal wrap_out chained to the vertical wrap_in

Test Plan:
- Reset release, en=1 -> cycle 1 hcount=0, vcount=0, frame_tick=1; cycle 2 hcount=1, frame_tick=0, line_tick=0.
- Run one line -> hcount=799 hblnk=0; hcount=800 hblnk=1; hsync=1 exactly for hcount 840..967 (128 cycles); hcount 1055 followed by hcount=0, vcount=1, line_tick=1.
- Run full frame -> vblnk=1 from vcount 600; vsync high for vcount 601..604 (4x1056 cycles); after vcount=627/hcount=1055, next is 0/0 with frame_tick; frame period 663168 cycles.
- en toggled low for 5 cycles at hcount=100 -> outputs frozen at 100, ticks 0; resumes at 101.
- rst asserted at hcount=500, vcount=300 -> next cycle all outputs at reset values; restart from 0/0.
- With VGA_TEST_PATTERN_EN, vcount=10 -> rgb=000 at hcount 0, 00F at 100, FFF at 799, 000 at 800.
